// File: rtl/sfifo2f_pfq.sv
//------------------------------------------------------------------------------
// sfifo2f_pfq - RAM FIFO with registered prefetch head stage and unified flags.
// Define SFIFO2F_PFQ_HWM_EN to enable the hwm_o high-water mark. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sfifo2f_pfq #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 3,
  parameter int PF_STAGES  = 2,
  parameter int CAP        = (1 << DEPTH_BITS) + PF_STAGES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [DEPTH_BITS:0]   af_lvl_i,
  input  logic [DEPTH_BITS:0]   ae_lvl_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic [DEPTH_BITS:0]   count_o,
  output logic [DEPTH_BITS:0]   ncount_o,
  output logic                  full_o,
  output logic                  fullm1_o,
  output logic                  empty_o,
  output logic                  emptyp2_o,
  output logic                  afull_o,
  output logic                  aempty_o,
  output logic                  ovf_o,
  output logic                  unf_o,
  output logic [DEPTH_BITS:0]   hwm_o
);

  localparam int              CW    = DEPTH_BITS + 1;
  localparam int              RAMD  = 1 << DEPTH_BITS;
  localparam logic [CW-1:0]   CAP_C = CW'(CAP);
  localparam logic [1:0]      PF_C  = 2'(PF_STAGES);

  logic [WIDTH-1:0] ram_q [RAMD];
  logic [WIDTH-1:0] pf_q  [PF_STAGES];
  logic [WIDTH-1:0] pf_d  [PF_STAGES];
  logic [WIDTH-1:0] pf_shift, ld_data;
  logic [CW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d, ncount_q;
  logic [1:0]       pf_cnt_q, pf_cnt_d, pf_keep;
  logic             full_q, fullm1_q, empty_q, emptyp2_q, afull_q, aempty_q;
  logic             ovf_q, unf_q;
  logic             wr_acc, rd_acc, ram_empty, room, xfer, bypass, wr_ram;

  // Popping the head shifts the second prefetch slot down (if there is one).
  if (PF_STAGES > 1) begin : g_pf_shift
    assign pf_shift = pf_q[1];
  end else begin : g_pf_hold
    assign pf_shift = pf_q[0];
  end

  always_comb begin
    wr_acc    = wr_i & ~full_q;
    rd_acc    = rd_i & ~empty_q;
    ram_empty = (wptr_q == rptr_q);
    pf_keep   = pf_cnt_q - {1'b0, rd_acc};
    room      = (pf_keep < PF_C);
    // RAM is non-empty only while the prefetch stage is full, so order holds.
    xfer      = room & ~ram_empty;
    bypass    = room & ram_empty & wr_acc;
    wr_ram    = wr_acc & ~bypass;
    ld_data   = xfer ? ram_q[rptr_q[DEPTH_BITS-1:0]] : din_i;
    wptr_d    = wptr_q + CW'(wr_ram);
    rptr_d    = rptr_q + CW'(xfer);
    count_d   = count_q + CW'(wr_acc) - CW'(rd_acc);
    pf_cnt_d  = pf_keep + {1'b0, xfer | bypass};
    for (int i = 0; i < PF_STAGES; i++) begin
      pf_d[i] = pf_q[i];
    end
    if (rd_acc) begin
      pf_d[0] = pf_shift;
    end
    for (int i = 0; i < PF_STAGES; i++) begin
      if ((xfer | bypass) && (pf_keep == 2'(i))) begin
        pf_d[i] = ld_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ram && !rst_i) begin
      ram_q[wptr_q[DEPTH_BITS-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      pf_cnt_q  <= '0;
      for (int i = 0; i < PF_STAGES; i++) begin
        pf_q[i] <= '0;
      end
      count_q   <= '0;
      ncount_q  <= CAP_C;
      full_q    <= 1'b0;
      fullm1_q  <= 1'b0;
      empty_q   <= 1'b1;
      emptyp2_q <= 1'b1;
      afull_q   <= (af_lvl_i == '0);
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      pf_cnt_q  <= pf_cnt_d;
      for (int i = 0; i < PF_STAGES; i++) begin
        pf_q[i] <= pf_d[i];
      end
      count_q   <= count_d;
      ncount_q  <= CAP_C - count_d;
      full_q    <= (count_d == CAP_C);
      fullm1_q  <= (count_d >= CAP_C - CW'(1));
      empty_q   <= (count_d == '0);
      emptyp2_q <= (count_d <= CW'(1));
      afull_q   <= (count_d >= af_lvl_i);
      aempty_q  <= (count_d <= ae_lvl_i);
      ovf_q     <= wr_i & full_q;
      unf_q     <= rd_i & empty_q;
    end
  end

`ifdef SFIFO2F_PFQ_HWM_EN
  logic [CW-1:0] hwm_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hwm_q <= '0;
    end else if (count_q > hwm_q) begin
      hwm_q <= count_q;
    end
  end
  assign hwm_o = hwm_q;
`else
  assign hwm_o = '0;
`endif

  assign dout_o    = pf_q[0];
  assign count_o   = count_q;
  assign ncount_o  = ncount_q;
  assign full_o    = full_q;
  assign fullm1_o  = fullm1_q;
  assign empty_o   = empty_q;
  assign emptyp2_o = emptyp2_q;
  assign afull_o   = afull_q;
  assign aempty_o  = aempty_q;
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_sfifo2f_pfq.sv
//------------------------------------------------------------------------------
// tb_sfifo2f_pfq - directed and randomized bench against a queue-based model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_sfifo2f_pfq;

  localparam int WIDTH = 16;
  localparam int DB    = 3;
  localparam int PF    = 2;
  localparam int CAP   = (1 << DB) + PF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             wr = 1'b0;
  logic             rd = 1'b0;
  logic [DB:0]      af_lvl = 4'd8;
  logic [DB:0]      ae_lvl = 4'd1;
  logic [WIDTH-1:0] dout;
  logic [DB:0]      count, ncount, hwm;
  logic             full, fullm1, empty, emptyp2, afull, aempty, ovf, unf;

  int n_vec = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] mq [$];
  int m_hwm = 0;

  always #5 clk = ~clk;

  sfifo2f_pfq #(.WIDTH(WIDTH), .DEPTH_BITS(DB), .PF_STAGES(PF)) u_dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .wr_i(wr), .rd_i(rd),
    .af_lvl_i(af_lvl), .ae_lvl_i(ae_lvl), .dout_o(dout),
    .count_o(count), .ncount_o(ncount), .full_o(full), .fullm1_o(fullm1),
    .empty_o(empty), .emptyp2_o(emptyp2), .afull_o(afull), .aempty_o(aempty),
    .ovf_o(ovf), .unf_o(unf), .hwm_o(hwm)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic rs);
    int sz, sz2;
    logic m_ovf, m_unf;
    @(negedge clk);
    wr = w; din = d; rd = r; rst = rs;
    @(posedge clk);
    sz = mq.size();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (rs) begin
      mq.delete();
      m_hwm = 0;
    end else begin
      m_ovf = w && (sz == CAP);
      m_unf = r && (sz == 0);
      if (sz > m_hwm) m_hwm = sz;
      if (r && sz > 0) void'(mq.pop_front());
      if (w && sz < CAP) mq.push_back(d);
    end
    sz2 = mq.size();
    #1;
    check_val("count",   32'(count),   32'(sz2));
    check_val("ncount",  32'(ncount),  32'(CAP - sz2));
    check_val("full",    32'(full),    32'(sz2 == CAP));
    check_val("fullm1",  32'(fullm1),  32'(sz2 >= CAP - 1));
    check_val("empty",   32'(empty),   32'(sz2 == 0));
    check_val("emptyp2", 32'(emptyp2), 32'(sz2 <= 1));
    check_val("afull",   32'(afull),   32'(sz2 >= int'(af_lvl)));
    check_val("aempty",  32'(aempty),  32'(sz2 <= int'(ae_lvl)));
    check_val("ovf",     32'(ovf),     32'(m_ovf));
    check_val("unf",     32'(unf),     32'(m_unf));
`ifdef SFIFO2F_PFQ_HWM_EN
    check_val("hwm",     32'(hwm),     32'(m_hwm));
`else
    check_val("hwm",     32'(hwm),     32'(0));
`endif
    if (sz2 > 0) check_val("dout", 32'(dout), 32'(mq[0]));
  endtask

  initial begin
    int pw, pr;
    logic [WIDTH-1:0] v;

    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    for (int i = 1; i <= 10; i++) step(1, WIDTH'(i), 0, 0);
    step(1, 16'hBEEF, 0, 0);
    step(0, '0, 0, 0);

    step(0, '0, 0, 1);
    step(1, 16'h1234, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    v = 16'h0100;
    for (int i = 0; i < 8; i++) begin step(1, v, 0, 0); v++; end
    for (int i = 0; i < 20; i++) begin step(1, v, 1, 0); v++; end

    step(0, '0, 0, 1);
    step(1, 16'h00AA, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    af_lvl = 4'd7;
    ae_lvl = 4'd2;
    step(0, '0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, WIDTH'(16'h0200 + i), 0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

    step(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, WIDTH'(16'h0300 + i), 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    step(1, 16'h0399, 0, 1);
    step(0, '0, 0, 0);

    af_lvl = 4'd0;
    ae_lvl = 4'd12;
    step(0, '0, 0, 1);
    step(1, 16'h0400, 0, 0);

    pw = 50;
    pr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        pw = int'($urandom_range(10, 90));
        pr = int'($urandom_range(10, 90));
      end
      if ($urandom_range(0, 19) == 0) begin
        af_lvl = 4'($urandom_range(0, 15));
        ae_lvl = 4'($urandom_range(0, 15));
      end
      step(int'($urandom_range(0, 99)) < pw, WIDTH'($urandom),
           int'($urandom_range(0, 99)) < pr, $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
